// File: rtl/frame_reader.sv
// Raster-order frame reader: walks the frame-buffer RAM once per start and
// emits a valid/ready pixel stream with coordinates, backed by a 2-entry FIFO.
module frame_reader #(
    parameter int unsigned W = 320,
    parameter int unsigned H = 240,
    parameter int unsigned V = 8,
    parameter int unsigned A = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_we_o,
    output logic [A-1:0]          ram_addr_o,
    input  logic [V-1:0]          ram_data_i,
    output logic [V-1:0]          pixel_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [$clog2(W)-1:0]  x_o,
    output logic [$clog2(H)-1:0]  y_o,
    output logic                  sof_o,
    output logic                  eol_o
);

    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);
    localparam logic [A-1:0]  LastAddr = A'(W * H - 1);
    localparam logic [XW-1:0] XLast    = XW'(W - 1);
    localparam logic [YW-1:0] YLast    = YW'(H - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e        state_q, state_d;
    logic [A-1:0]  addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic          done_q;
    logic [V-1:0]  mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic          pop;
    logic          issue;
    logic          clear;
    logic [2:0]    occ;

    assign valid_o    = (count_q != 2'd0);
    assign pixel_o    = mem_q[rd_ptr_q];
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign sof_o      = valid_o && (x_q == '0) && (y_q == '0);
    assign eol_o      = valid_o && (x_q == XLast);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign ram_we_o   = 1'b0;
    assign ram_addr_o = addr_q;

    always_comb begin
        pop        = valid_o && ready_i;
        // Slots already claimed once this cycle's pop retires; issue only if one is free.
        occ        = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == StRead) && (occ < 3'd2);
        state_d    = state_q;
        addr_d     = addr_q;
        inflight_d = issue;
        clear      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRead;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            StRead: begin
                if (issue) begin
                    if (addr_q == LastAddr) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + A'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && (x_q == XLast) && (y_q == YLast)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            done_q     <= (state_q == StDrain) && (state_d == StIdle);
            if (clear) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
                x_q      <= '0;
                y_q      <= '0;
            end else begin
                if (inflight_q) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                    if (x_q == XLast) begin
                        x_q <= '0;
                        y_q <= (y_q == YLast) ? '0 : y_q + YW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
                count_q <= count_q + 2'(inflight_q) - 2'(pop);
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (inflight_q) begin
            mem_q[wr_ptr_q] <= ram_data_i;
        end
    end

endmodule
